ysyx_22040125_wb_arbiter: RTL



---
 rtl/ysyx_22040125_wb_arbiter_if.sv | 29 ++
 rtl/ysyx_22040125_wb_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/ysyx_22040125_wb_arbiter_if.sv
// Bus between the execution-side write requesters, the write-back arbiter and the
// register-file write port, including the decode forwarding probe.
interface ysyx_22040125_wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic               hold;
    logic [N_REQ-1:0]   req_valid;
    logic [5*N_REQ-1:0] req_rd;
    logic [64*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               reg_wen;
    logic [4:0]         reg_waddr;
    logic [63:0]        reg_wdata;
    logic [4:0]         fwd_addr_rs1;
    logic [4:0]         fwd_addr_rs2;
    logic               fwd_hit_rs1;
    logic               fwd_hit_rs2;
    logic [63:0]        fwd_data;

    modport slave (
        input  hold, req_valid, req_rd, req_data, fwd_addr_rs1, fwd_addr_rs2,
        output req_ready, reg_wen, reg_waddr, reg_wdata, fwd_hit_rs1, fwd_hit_rs2, fwd_data
    );

    modport master (
        output hold, req_valid, req_rd, req_data, fwd_addr_rs1, fwd_addr_rs2,
        input  req_ready, reg_wen, reg_waddr, reg_wdata, fwd_hit_rs1, fwd_hit_rs2, fwd_data
    );
endinterface

// File: rtl/ysyx_22040125_wb_arbiter.sv
// Write-back arbiter: grants one register-write requester per cycle and drives the
// register-file write port from a registered stage. WB_ARB_ROUND_ROBIN_EN selects rotating priority.
module ysyx_22040125_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22040125_wb_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int RD_W   = 5;
    localparam int DATA_W = 64;

    logic [IDX_W-1:0]  w_base;
    logic              w_pick_vld;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_grant_en;
    logic [N_REQ-1:0]  w_ready;
    logic [RD_W-1:0]   w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              r_wen;
    logic [RD_W-1:0]   r_waddr;
    logic [DATA_W-1:0] r_wdata;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;

    // Pointer moves just past the grantee so it becomes lowest priority next time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_en) begin
            r_ptr <= wrap_idx(w_pick_idx, 32'sd1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    // First valid requester in search order starting at the priority base
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_pick_vld && bus.req_valid[wrap_idx(w_base, k)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = wrap_idx(w_base, k);
            end else begin
                w_pick_idx = w_pick_idx;
            end
        end
    end

    // Grant ignores everything the requesters drive except valid, so no loop forms
    assign w_grant_en = w_pick_vld & ~bus.hold & ~rst;

    // One-hot ready vector for the chosen requester
    always_comb begin
        w_ready = '0;
        if (w_grant_en) begin
            w_ready[w_pick_idx] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    assign w_sel_rd   = bus.req_rd[RD_W*int'(w_pick_idx) +: RD_W];
    assign w_sel_data = bus.req_data[DATA_W*int'(w_pick_idx) +: DATA_W];

    // Output stage: x0 writes are consumed without enabling the port; address/data otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_grant_en) begin
            r_wen <= (w_sel_rd != 5'd0);
            if (w_sel_rd != 5'd0) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end else begin
            r_wen <= 1'b0;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.reg_wen     = r_wen;
    assign bus.reg_waddr   = r_waddr;
    assign bus.reg_wdata   = r_wdata;
    assign bus.fwd_data    = r_wdata;
    assign bus.fwd_hit_rs1 = r_wen & (r_waddr == bus.fwd_addr_rs1) & (bus.fwd_addr_rs1 != 5'd0);
    assign bus.fwd_hit_rs2 = r_wen & (r_waddr == bus.fwd_addr_rs2) & (bus.fwd_addr_rs2 != 5'd0);
endmodule
